lab10_mem_alu: RTL
==================

LAB10_MEM_ALU -- requirements
Module: lab10_mem_alu

Interface
Parameters:
- REQ-001: DATA_W, default 8, shall set the word width of memory, operands and result.
- REQ-002: ADDR_W, default 3, shall set the address width; memory depth DEPTH = 2**ADDR_W.

Ports:
- REQ-003: clk  input  1  shall be the single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  shall be the reset: asynchronous, active-low (rst=0 resets).
- REQ-005: start  input  1  shall request an operation; sampled only in IDLE.
- REQ-006: op  input  2  shall select the operation: 00 add, 01 sub, 10 and, 11 xor.
- REQ-007: addr1 and addr2  input  ADDR_W each  shall give the operand A and operand B addresses; captured on accept.
- REQ-008: wr_en  input  1  shall be the host write strobe.
- REQ-009: wr_addr  input  ADDR_W  shall be the host write address.
- REQ-010: wr_data  input  DATA_W  shall be the host write data.
- REQ-011: result  output  DATA_W  shall hold the registered result of the last operation.
- REQ-012: carry  output  1  shall be the registered carry (add) or borrow (sub) flag.
- REQ-013: busy  output  1  shall be high in any state other than IDLE.
- REQ-014: done  output  1  shall pulse high for exactly one cycle per completed operation.

Function
- REQ-015: FSM states shall be IDLE, READ1, READ2, EXEC and DONE.
- REQ-016: In IDLE, start=1 at an edge shall capture addr1, addr2 and op (and addr_dst when present), and move to READ1.
- REQ-017: READ1 shall latch A = mem[addr1]; READ2 shall latch B = mem[addr2]; each read takes one edge.
- REQ-018: In EXEC, the next edge shall register result and carry and move to DONE.
- REQ-019: DONE shall assert done for one cycle; the next edge shall return to IDLE.
- REQ-020: Latency: if start is accepted at edge N, done shall be high between edge N+4 and edge N+5.
- REQ-021: Back-to-back operation: start may be accepted again at edge N+5.
- REQ-022: Arithmetic shall be modulo 2**DATA_W.
- REQ-023: For add, carry shall be the bit DATA_W carry-out.
- REQ-024: For sub, carry shall be 1 when A < B (unsigned).
- REQ-025: For and and xor, carry shall be 0.
- REQ-026: start while busy=1 shall be ignored and not queued.
- REQ-027: A host write shall take effect only when wr_en=1 in IDLE; wr_en in any other state shall be ignored.
- REQ-028: When wr_en and start are both 1 in IDLE, the write and the accept shall both occur at that edge, and the operation shall read the newly written data.
- REQ-029: result and carry shall hold their values until the next EXEC completes.
- REQ-030: addr1 may equal addr2; A and B then carry the same value.

Reset
- REQ-031: rst=0 shall immediately, independent of clk, force state IDLE, result=0, carry=0, busy=0 and done=0, and clear the A and B registers.
- REQ-032: rst=0 shall preload mem[i] = i (truncated to DATA_W) for every i.
- REQ-033: Reset asserted mid-operation shall abort the operation with no done pulse and no writeback.

Configuration
- REQ-034: Macro LAB10_WRITEBACK_EN, when defined, shall add input addr_dst (ADDR_W, captured on accept), and the EXEC edge shall also write the computed result to mem[addr_dst].
- REQ-035: When LAB10_WRITEBACK_EN is undefined, port addr_dst shall not exist and memory shall change only via the host write port and reset.
- REQ-036: The cycle timing of REQ-020 shall be identical with and without LAB10_WRITEBACK_EN.

Verification (defaults, after reset)
- REQ-037: start, op=00, addr1=1, addr2=2 -> done at accept+4, result=8'h03, carry=0; start asserted during busy has no effect.
- REQ-038: op=01, addr1=2, addr2=4 -> result=8'hFE, carry=1.
- REQ-039: host write 8'hFF to address 3 in IDLE together with start, op=00, addr1=3, addr2=1 -> result=8'h00, carry=1.
- REQ-040: op=11, addr1=6, addr2=5 -> result=8'h03, carry=0; then op=10, addr1=3, addr2=7 -> result=8'h03.
- REQ-041: With LAB10_WRITEBACK_EN: op=00, addr1=6, addr2=5, addr_dst=7 -> result=8'h0B; then op=00, addr1=7, addr2=0 -> result=8'h0B.
- REQ-042: rst=0 pulsed while in READ2 -> busy=0, done never pulses, result=0; then op=00, addr1=4, addr2=4 -> result=8'h08.

Source files
------------

// File: rtl/lab10_mem_alu.sv
// Small register-file ALU: two sequential operand reads, one execute step, one-cycle done pulse.
// Optional LAB10_WRITEBACK_EN adds addr_dst and writes the result back to memory on the EXEC edge.
module lab10_mem_alu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
`ifdef LAB10_WRITEBACK_EN
  input  logic [ADDR_W-1:0] addr_dst,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, READ1, READ2, EXEC, DONE} state_t;

  state_t                        state, state_nx;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [ADDR_W-1:0]             a1_q, a2_q;
  logic [1:0]                    op_q;
  logic [DATA_W-1:0]             a_q, b_q;
  logic [DATA_W:0]               alu;
  logic                          accept, ld_a, ld_b, ld_res, host_we;
`ifdef LAB10_WRITEBACK_EN
  logic [ADDR_W-1:0]             dst_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ1;
      READ1:   state_nx = READ2;
      READ2:   state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    accept  = (state == IDLE) && start;
    host_we = (state == IDLE) && wr_en;
    ld_a    = (state == READ1);
    ld_b    = (state == READ2);
    ld_res  = (state == EXEC);
  end

  // Bit DATA_W is carry-out for add and borrow (A < B) for sub.
  always_comb begin
    alu = '0;
    case (op_q)
      2'b00: alu = {1'b0, a_q} + {1'b0, b_q};
      2'b01: alu = {1'b0, a_q} - {1'b0, b_q};
      2'b10: alu = {1'b0, a_q & b_q};
      2'b11: alu = {1'b0, a_q ^ b_q};
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1_q <= '0;
      a2_q <= '0;
      op_q <= '0;
`ifdef LAB10_WRITEBACK_EN
      dst_q <= '0;
`endif
    end else if (accept) begin
      a1_q <= addr1;
      a2_q <= addr2;
      op_q <= op;
`ifdef LAB10_WRITEBACK_EN
      dst_q <= addr_dst;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      if (ld_a)   a_q <= mem[a1_q];
      if (ld_b)   b_q <= mem[a2_q];
      if (ld_res) begin
        result <= alu[DATA_W-1:0];
        carry  <= alu[DATA_W];
      end
    end
  end

  // Host writes happen only in IDLE and writeback only in EXEC, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else begin
      if (host_we) mem[wr_addr] <= wr_data;
`ifdef LAB10_WRITEBACK_EN
      if (ld_res)  mem[dst_q] <= alu[DATA_W-1:0];
`endif
    end
  end

  // done is registered off the DONE state, so it lands one cycle later while the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done <= 1'b0;
    else      done <= (state == DONE);
  end
endmodule
